// File: rtl/skein_key_schedule.sv
// Skein-1024 key schedule feeder: loads a key/tweak, derives K16 and T2, then streams
// NUM_INJ word-rotated extended keys. Define SKEIN_KS_PARITY_1CYC_EN for a single-cycle parity fold.
module skein_key_schedule #(
  parameter int          NUM_INJ   = 21,
  parameter logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] key_in,
  input  logic [127:0]  tweak_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1087:0] key_out,
  output logic [191:0]  type_out,
  output logic [4:0]    inj_num,
  output logic          last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARITY,
    S_ARM,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [16:0][63:0] key_q, key_d;
  logic [191:0]      tweak_q, tweak_d;
  logic [4:0]        inj_q, inj_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              last_q, last_d;
  logic [63:0]       parity_acc;
`ifndef SKEIN_KS_PARITY_1CYC_EN
  logic [1:0]        phase_q, phase_d;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    tweak_d     = tweak_q;
    inj_d       = inj_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    parity_acc  = key_q[16];
`ifndef SKEIN_KS_PARITY_1CYC_EN
    phase_d     = phase_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          key_d[15:0] = key_in;
          key_d[16]   = KS_PARITY;
          tweak_d     = {tweak_in[63:0] ^ tweak_in[127:64], tweak_in};
          inj_d       = 5'd0;
          in_ready_d  = 1'b0;
`ifndef SKEIN_KS_PARITY_1CYC_EN
          phase_d     = 2'd0;
`endif
          state_d     = S_PARITY;
        end
      end

      S_PARITY: begin
`ifdef SKEIN_KS_PARITY_1CYC_EN
        for (int i = 0; i < 16; i++) parity_acc = parity_acc ^ key_q[5'(i)];
        key_d[16] = parity_acc;
        state_d   = S_ARM;
`else
        // Phase p folds words 4p..4p+3 into the accumulator held in word 16.
        for (int k = 0; k < 4; k++) parity_acc = parity_acc ^ key_q[{1'b0, phase_q, 2'(k)}];
        key_d[16] = parity_acc;
        phase_d   = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = S_ARM;
`endif
      end

      S_ARM: begin
        out_valid_d = 1'b1;
        last_d      = (NUM_INJ == 1);
        state_d     = S_RUN;
      end

      S_RUN: begin
        if (out_ready) begin
          // Rotate down one word so word j of the next beat is K[(s+1+j) mod 17].
          key_d = {key_q[0], key_q[16:1]};
          if (last_q) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
            in_ready_d  = 1'b1;
            inj_d       = 5'd0;
            state_d     = S_IDLE;
          end else begin
            inj_d  = inj_q + 5'd1;
            last_d = ((inj_q + 5'd1) == 5'(NUM_INJ - 1));
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the key register is an ordinary flop bank driving key_out directly, so it is reset
  // along with everything else; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      tweak_q     <= '0;
      inj_q       <= 5'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
`ifndef SKEIN_KS_PARITY_1CYC_EN
      phase_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      tweak_q     <= tweak_d;
      inj_q       <= inj_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
`ifndef SKEIN_KS_PARITY_1CYC_EN
      phase_q     <= phase_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign key_out   = key_q;
  assign type_out  = tweak_q;
  assign inj_num   = inj_q;
  assign last      = last_q;

endmodule

// File: tb/tb_skein_key_schedule.sv
// Self-checking bench for skein_key_schedule: random and directed keys against an array model
// of the extended key (K16 = C240 ^ K0..K15, beat s word j = K[(s+j) mod 17]).
module tb_skein_key_schedule;

  localparam int          NUM_INJ = 21;
  localparam logic [63:0] C240    = 64'h1BD11BDAA9FC1A22;
`ifdef SKEIN_KS_PARITY_1CYC_EN
  localparam int          LAT     = 2;
`else
  localparam int          LAT     = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] key_in;
  logic [127:0]  tweak_in;
  logic          out_valid;
  logic          out_ready;
  logic [1087:0] key_out;
  logic [191:0]  type_out;
  logic [4:0]    inj_num;
  logic          last;

  skein_key_schedule #(.NUM_INJ(NUM_INJ), .KS_PARITY(C240)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_in    (key_in),
    .tweak_in  (tweak_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .key_out   (key_out),
    .type_out  (type_out),
    .inj_num   (inj_num),
    .last      (last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_last   = 0;

  logic [63:0]  mk [17];
  logic [191:0] mt;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] rand_key();
    logic [1023:0] k;
    for (int i = 0; i < 32; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic void load_model(input logic [1023:0] k, input logic [127:0] t);
    logic [63:0] p;
    p = C240;
    for (int i = 0; i < 16; i++) begin
      mk[i] = k[64*i +: 64];
      p     = p ^ mk[i];
    end
    mk[16] = p;
    mt     = {t[63:0] ^ t[127:64], t};
  endfunction

  task automatic check_beat(input int s);
    check("out_valid", 192'(out_valid), 192'(1'b1));
    check("inj_num", 192'(inj_num), 192'(s));
    check("last", 192'(last), 192'(s == NUM_INJ - 1));
    check("type_out", type_out, mt);
    check("in_ready_busy", 192'(in_ready), 192'(1'b0));
    for (int j = 0; j < 17; j++)
      check($sformatf("key s%0d w%0d", s, j), 192'(key_out[64*j +: 64]), 192'(mk[(s + j) % 17]));
  endtask

  // Called at a negedge with in_ready expected high (now or soon); accept happens on the next edge.
  task automatic do_load(input logic [1023:0] k, input logic [127:0] t, output int waited);
    in_valid = 1'b1;
    key_in   = k;
    tweak_in = t;
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_at_load", 192'(in_ready), 192'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    load_model(k, t);
  endtask

  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 192'(lat), 192'(LAT));
  endtask

  task automatic stream(input int stop_at, input int stall_at, input int stall_len,
                        input bit rand_stall, input bit pattern);
    int n;
    for (int s = 0; s < stop_at; s++) begin
      check_beat(s);
      if (pattern) begin
        if (s == 0) begin
          check("pat_t2", 192'(type_out[191:128]), 192'(64'h3333333333333333));
          check("pat_s0_w0", 192'(key_out[63:0]), 192'(64'd0));
          check("pat_s0_w16", 192'(key_out[1087:1024]), 192'(C240));
        end
        if (s == 1) begin
          check("pat_s1_w0", 192'(key_out[63:0]), 192'(64'd1));
          check("pat_s1_w15", 192'(key_out[1023:960]), 192'(C240));
          check("pat_s1_w16", 192'(key_out[1087:1024]), 192'(64'd0));
        end
        if (s == 20) begin
          check("pat_s20_w0", 192'(key_out[63:0]), 192'(64'd3));
          check("pat_s20_last", 192'(last), 192'(1'b1));
        end
      end
      n = (s == stall_at) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      out_ready = 1'b0;
      repeat (n) begin
        @(negedge clk);
        check_beat(s);
      end
      out_ready = 1'b1;
      if (last) n_last++;
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (stop_at == NUM_INJ) begin
      check("end_out_valid", 192'(out_valid), 192'(1'b0));
      check("end_in_ready", 192'(in_ready), 192'(1'b1));
      check("end_last", 192'(last), 192'(1'b0));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 192'(in_ready), 192'(1'b1));
    check({tag, "_out_valid"}, 192'(out_valid), 192'(1'b0));
    check({tag, "_last"}, 192'(last), 192'(1'b0));
    check({tag, "_inj_num"}, 192'(inj_num), 192'(0));
    check({tag, "_type_out"}, type_out, 192'(0));
    check({tag, "_key_zero"}, 192'(|key_out), 192'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] k, kb;
    logic [127:0]  t, tb;
    int            w, last_before;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key_in    = '0;
    tweak_in  = '0;
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Zero key and tweak.
    do_load('0, '0, w);
    wait_valid();
    check("zero_w16", 192'(key_out[1087:1024]), 192'(C240));
    check("zero_low", 192'(|key_out[1023:0]), 192'(1'b0));
    check("zero_type", type_out, 192'(0));
    stream(NUM_INJ, -1, 0, 1'b0, 1'b0);

    // Word i = i, with directed expectations.
    for (int i = 0; i < 16; i++) k[64*i +: 64] = 64'(i);
    t = {64'h2222222222222222, 64'h1111111111111111};
    do_load(k, t, w);
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b0, 1'b1);

    // Same key with a 10-cycle stall at s=7.
    do_load(k, t, w);
    wait_valid();
    stream(NUM_INJ, 7, 10, 1'b0, 1'b0);

    // Busy input ignored; second key taken on the first edge after the last beat.
    k  = rand_key();
    t  = {$urandom, $urandom, $urandom, $urandom};
    kb = rand_key();
    tb = {$urandom, $urandom, $urandom, $urandom};
    do_load(k, t, w);
    in_valid = 1'b1;
    key_in   = kb;
    tweak_in = tb;
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b1, 1'b0);
    do_load(kb, tb, w);
    check("second_accept_wait", 192'(w), 192'(0));
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b1, 1'b0);

    // Asynchronous reset at s=12, then a fresh load.
    do_load(rand_key(), {$urandom, $urandom, $urandom, $urandom}, w);
    wait_valid();
    last_before = n_last;
    stream(12, -1, 0, 1'b1, 1'b0);
    check_beat(12);
    #1 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk);
    check_reset_state("midreset_hold");
    rst_n = 1'b1;
    check("midreset_no_last", 192'(n_last - last_before), 192'(0));
    do_load(rand_key(), {$urandom, $urandom, $urandom, $urandom}, w);
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b0, 1'b0);

    // Two back-to-back keys under continuous ready.
    last_before = n_last;
    do_load(rand_key(), {$urandom, $urandom, $urandom, $urandom}, w);
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b0, 1'b0);
    do_load(rand_key(), {$urandom, $urandom, $urandom, $urandom}, w);
    check("b2b_accept_wait", 192'(w), 192'(0));
    wait_valid();
    stream(NUM_INJ, -1, 0, 1'b0, 1'b0);
    check("b2b_last_count", 192'(n_last - last_before), 192'(2));
    check("total_last_count", 192'(n_last), 192'(8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
